// File: rtl/load_align_ext.sv
// load_align_ext
//
// Load-data alignment and extension unit with an output queue. It sits between
// the data-memory read port and register-file write-back. Every accepted load
// beat picks a byte, halfword, word or doubleword out of the memory word by
// address offset, extends it to DATA_W bits and queues it with its destination
// tag. Misaligned beats are queued as data 0 with a misalign flag and counted.
//
// Optional feature macro: LOAD_SIGNEXT_EN
//   defined   : in_unsigned=0 sign-extends sub-word fields, in_unsigned=1 zero-extends
//   undefined : all sub-word fields zero-extend regardless of in_unsigned
//   Full-width accesses are never extended in either mode.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. valid, once raised, may be held until the transfer happens; ready never
// depends combinationally on the partner's valid. in_ready = !full and is a
// function of the occupancy count only. out_valid = !empty. flush wins over any
// push or pop in the same cycle, so a beat offered then is dropped.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous queue clear (misalign_cnt is kept)
//   in_valid/in_ready     load beat handshake
//   in_data               raw memory word
//   in_off                low address bits (byte offset)
//   in_size               00 byte, 01 half, 10 word, 11 dword
//   in_unsigned           LBU/LHU/LWU marker
//   in_tag                destination register
//   out_valid/out_ready   write-back handshake
//   out_data/out_tag/out_misalign   head-of-queue entry
//   misalign_cnt          saturating count of accepted misaligned beats

module load_align_ext #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 2,
    parameter int TAG_W      = 5,
    parameter bit BIG_ENDIAN = 1'b0,
    localparam int OFF_W     = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_misalign,
    output logic [7:0]        misalign_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SH_W  = $clog2(DATA_W) + 1;
    localparam logic [1:0]     FULL_SIZE = (DATA_W == 64) ? 2'b11 : 2'b10;
    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Field extraction and extension
    // ------------------------------------------------------------------
    logic [SH_W-1:0]   field_bits;
    logic [SH_W-1:0]   byte_shift;
    logic [SH_W-1:0]   shamt;
    logic [OFF_W-1:0]  align_mask;
    logic              misalign;
    logic              sign_en;
    logic              field_msb;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] field_mask;
    logic [DATA_W-1:0] ext_data;
    logic [DATA_W-1:0] push_data;

`ifdef LOAD_SIGNEXT_EN
    assign sign_en = !in_unsigned;
`else
    logic unused_unsigned;
    assign unused_unsigned = in_unsigned;
    assign sign_en         = 1'b0;
`endif

    always_comb begin
        field_bits = SH_W'(8) << in_size;
        byte_shift = SH_W'({in_off, 3'b000});
        // Big-endian: byte at in_off is the field MSB, so the field's LSB sits
        // (DATA_W - 8*off - width) bits above bit 0.
        if (BIG_ENDIAN) begin
            shamt = SH_W'(DATA_W) - byte_shift - field_bits;
        end else begin
            shamt = byte_shift;
        end
        align_mask = OFF_W'((4'd1 << in_size) - 4'd1);
        misalign   = ((in_off & align_mask) != '0) ||
                     ((DATA_W == 32) && (in_size == 2'b11));
        shifted    = in_data >> shamt;
        field_mask = (in_size == FULL_SIZE) ? '1
                   : ((DATA_W'(1) << field_bits) - DATA_W'(1));
        // Top bit of the field: the one mask bit not present in mask>>1.
        field_msb  = |(shifted & field_mask & ~(field_mask >> 1));
        ext_data   = shifted & field_mask;
        if (sign_en && field_msb) begin
            ext_data = ext_data | ~field_mask;
        end
        push_data  = misalign ? '0 : ext_data;
    end

    // ------------------------------------------------------------------
    // Output queue
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [TAG_W-1:0]  mem_tag  [DEPTH];
    logic              mem_mis  [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic              push;
    logic              pop;

    assign in_ready     = (count != FULL_CNT);
    assign out_valid    = (count != '0);
    assign push         = in_valid && in_ready && !flush;
    assign pop          = out_valid && out_ready && !flush;
    assign out_data     = mem_data[rd_ptr];
    assign out_tag      = mem_tag[rd_ptr];
    assign out_misalign = mem_mis[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            misalign_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_tag[i]  <= '0;
                mem_mis[i]  <= 1'b0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_tag[wr_ptr]  <= in_tag;
                mem_mis[wr_ptr]  <= misalign;
                wr_ptr           <= wr_ptr + PTR_W'(1);
                if (misalign && (misalign_cnt != 8'hFF)) begin
                    misalign_cnt <= misalign_cnt + 8'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_ext.sv
// tb_load_align_ext
//
// Two instances: index 0 is little-endian with DEPTH=2, index 1 is big-endian
// with DEPTH=4, both DATA_W=32. Directed cases cover extension modes, endian
// ordering, misalignment and its saturating counter, backpressure with pointer
// wrap, flush priority and asynchronous reset. A randomized phase compares both
// instances against a byte-level reference model and an expected queue.
// Follows LOAD_SIGNEXT_EN exactly as the design does.

module tb_load_align_ext;

    logic        clk;
    logic        rst_n;
    logic        flush        [2];
    logic        in_valid     [2];
    logic        in_ready     [2];
    logic [31:0] in_data      [2];
    logic [1:0]  in_off       [2];
    logic [1:0]  in_size      [2];
    logic        in_unsigned  [2];
    logic [4:0]  in_tag       [2];
    logic        out_valid    [2];
    logic        out_ready    [2];
    logic [31:0] out_data     [2];
    logic [4:0]  out_tag      [2];
    logic        out_misalign [2];
    logic [7:0]  misalign_cnt [2];

    int n_checks = 0;
    int n_pass   = 0;
    int mcnt [2];
    logic [37:0] exp_q0[$];
    logic [37:0] exp_q1[$];

`ifdef LOAD_SIGNEXT_EN
    localparam logic [31:0] SX_BYTE_EXP = 32'hFFFFFF80;
    localparam logic [31:0] SX_HALF_EXP = 32'hFFFFABCD;
`else
    localparam logic [31:0] SX_BYTE_EXP = 32'h00000080;
    localparam logic [31:0] SX_HALF_EXP = 32'h0000ABCD;
`endif

    load_align_ext #(.DATA_W(32), .DEPTH(2), .TAG_W(5), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_off(in_off[0]), .in_size(in_size[0]), .in_unsigned(in_unsigned[0]),
        .in_tag(in_tag[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_tag(out_tag[0]), .out_misalign(out_misalign[0]),
        .misalign_cnt(misalign_cnt[0])
    );

    load_align_ext #(.DATA_W(32), .DEPTH(4), .TAG_W(5), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_off(in_off[1]), .in_size(in_size[1]), .in_unsigned(in_unsigned[1]),
        .in_tag(in_tag[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_tag(out_tag[1]), .out_misalign(out_misalign[1]),
        .misalign_cnt(misalign_cnt[1])
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int i);
        flush[i]       = 1'b0;
        in_valid[i]    = 1'b0;
        out_ready[i]   = 1'b0;
        in_data[i]     = '0;
        in_off[i]      = '0;
        in_size[i]     = '0;
        in_unsigned[i] = 1'b0;
        in_tag[i]      = '0;
    endtask

    task automatic beat(input int i, input logic [31:0] d, input logic [1:0] off,
                        input logic [1:0] sz, input logic uns, input logic [4:0] tag);
        in_valid[i]    = 1'b1;
        in_data[i]     = d;
        in_off[i]      = off;
        in_size[i]     = sz;
        in_unsigned[i] = uns;
        in_tag[i]      = tag;
    endtask

    // Reference: build the field byte by byte from the memory word.
    function automatic logic [32:0] model_load(input logic [31:0] d, input int off,
                                               input int sz, input bit uns, input bit be);
        logic [7:0]  b [4];
        int          nb;
        logic [31:0] v;
        bit          sx;
        for (int k = 0; k < 4; k++) b[k] = be ? d[31-8*k -: 8] : d[8*k +: 8];
        nb = 1 << sz;
        if (sz == 3 || (off % nb) != 0) return {1'b1, 32'h0};
        v = 32'h0;
        for (int j = 0; j < nb; j++) begin
            if (be) v = (v << 8) | 32'(b[off+j]);
            else    v = v | (32'(b[off+j]) << (8*j));
        end
`ifdef LOAD_SIGNEXT_EN
        sx = !uns;
`else
        sx = uns & 1'b0;
`endif
        if (sx && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
        return {1'b0, v};
    endfunction

    // One randomized cycle on both instances, scoreboard updated alongside.
    task automatic rand_step();
        for (int i = 0; i < 2; i++) begin
            int          qs  = (i == 0) ? exp_q0.size() : exp_q1.size();
            int          dep = (i == 0) ? 2 : 4;
            logic [37:0] head;
            logic [32:0] m;
            int          sz;
            int          off;
            int          nb;
            check("rnd_out_valid", out_valid[i], qs != 0);
            check("rnd_in_ready", in_ready[i], qs != dep);
            check("rnd_mcnt", misalign_cnt[i], mcnt[i]);
            if (qs != 0) begin
                head = (i == 0) ? exp_q0[0] : exp_q1[0];
                check("rnd_data", out_data[i], head[31:0]);
                check("rnd_tag", out_tag[i], head[36:32]);
                check("rnd_mis", out_misalign[i], head[37]);
            end
            sz  = $urandom_range(0, 3);
            nb  = 1 << sz;
            off = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0 && nb <= 4) off = (off / nb) * nb;
            flush[i]       = ($urandom_range(0, 31) == 0);
            in_valid[i]    = ($urandom_range(0, 9) < 7);
            out_ready[i]   = ($urandom_range(0, 9) < 6);
            in_data[i]     = $urandom;
            in_off[i]      = 2'(off);
            in_size[i]     = 2'(sz);
            in_unsigned[i] = 1'($urandom_range(0, 1));
            in_tag[i]      = 5'($urandom_range(0, 31));
            if (flush[i]) begin
                if (i == 0) exp_q0.delete(); else exp_q1.delete();
            end else begin
                if (qs != 0 && out_ready[i]) begin
                    if (i == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
                end
                if (in_valid[i] && qs != dep) begin
                    m = model_load(in_data[i], off, sz, in_unsigned[i], i == 1);
                    if (i == 0) exp_q0.push_back({m[32], in_tag[i], m[31:0]});
                    else        exp_q1.push_back({m[32], in_tag[i], m[31:0]});
                    if (m[32] && mcnt[i] < 255) mcnt[i]++;
                end
            end
        end
        step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        idle(0);
        idle(1);
        step();
        step();
        // reset state
        for (int i = 0; i < 2; i++) begin
            check("rst_out_valid", out_valid[i], 1'b0);
            check("rst_in_ready", in_ready[i], 1'b1);
            check("rst_mcnt", misalign_cnt[i], 8'd0);
            check("rst_data", out_data[i], 32'h0);
            check("rst_tag", out_tag[i], 5'h0);
            check("rst_mis", out_misalign[i], 1'b0);
        end
        rst_n = 1'b1;
        step();

        // sign/zero extension of a byte, little-endian
        beat(0, 32'h80FF7F01, 2'd3, 2'b00, 1'b0, 5'd7);
        step();
        in_valid[0] = 1'b0;
        check("sx_valid", out_valid[0], 1'b1);
        check("sx_byte", out_data[0], SX_BYTE_EXP);
        check("sx_tag", out_tag[0], 5'd7);
        check("sx_mis", out_misalign[0], 1'b0);
        out_ready[0] = 1'b1;
        step();
        out_ready[0] = 1'b0;
        check("sx_drained", out_valid[0], 1'b0);

        // big-endian halfword, signed then unsigned
        beat(1, 32'h1234ABCD, 2'd2, 2'b01, 1'b0, 5'd3);
        step();
        beat(1, 32'h1234ABCD, 2'd2, 2'b01, 1'b1, 5'd4);
        step();
        in_valid[1] = 1'b0;
        check("be_half_s", out_data[1], SX_HALF_EXP);
        check("be_tag_s", out_tag[1], 5'd3);
        out_ready[1] = 1'b1;
        step();
        check("be_half_u", out_data[1], 32'h0000ABCD);
        check("be_tag_u", out_tag[1], 5'd4);
        step();
        out_ready[1] = 1'b0;
        check("be_drained", out_valid[1], 1'b0);

        // misalignment
        beat(0, 32'hDEADBEEF, 2'd1, 2'b01, 1'b0, 5'd1);
        step();
        beat(0, 32'hCAFEF00D, 2'd2, 2'b10, 1'b0, 5'd2);
        step();
        in_valid[0] = 1'b0;
        check("mis_cnt2", misalign_cnt[0], 8'd2);
        check("mis_flag1", out_misalign[0], 1'b1);
        check("mis_data1", out_data[0], 32'h0);
        check("mis_tag1", out_tag[0], 5'd1);
        check("mis_full", in_ready[0], 1'b0);
        out_ready[0] = 1'b1;
        step();
        check("mis_flag2", out_misalign[0], 1'b1);
        check("mis_data2", out_data[0], 32'h0);
        check("mis_tag2", out_tag[0], 5'd2);
        step();
        check("mis_drained", out_valid[0], 1'b0);
        for (int n = 0; n < 300; n++) begin
            beat(0, $urandom, 2'd3, 2'b01, 1'b0, 5'(n));
            step();
        end
        in_valid[0] = 1'b0;
        step();
        out_ready[0] = 1'b0;
        check("mis_sat", misalign_cnt[0], 8'd255);
        check("mis_sat_drained", out_valid[0], 1'b0);

        // backpressure and pointer wrap, DEPTH=2
        beat(0, 32'hA0000001, 2'd0, 2'b10, 1'b0, 5'd1);
        step();
        beat(0, 32'hA0000002, 2'd0, 2'b10, 1'b0, 5'd2);
        step();
        check("bp_full", in_ready[0], 1'b0);
        beat(0, 32'hA0000003, 2'd0, 2'b10, 1'b0, 5'd3);
        step();
        check("bp_held", in_ready[0], 1'b0);
        check("bp_head1", out_tag[0], 5'd1);
        check("bp_data1", out_data[0], 32'hA0000001);
        out_ready[0] = 1'b1;
        step();
        check("bp_head2", out_tag[0], 5'd2);
        check("bp_ready", in_ready[0], 1'b1);
        step();
        check("bp_head3", out_tag[0], 5'd3);
        check("bp_data3", out_data[0], 32'hA0000003);
        check("bp_valid3", out_valid[0], 1'b1);
        in_valid[0] = 1'b0;
        step();
        out_ready[0] = 1'b0;
        check("bp_drained", out_valid[0], 1'b0);

        // flush overrides push and pop; offered misaligned beat not counted
        beat(1, 32'h11223344, 2'd0, 2'b10, 1'b0, 5'd5);
        step();
        check("fl_one", out_valid[1], 1'b1);
        flush[1] = 1'b1;
        beat(1, 32'h55667788, 2'd1, 2'b01, 1'b0, 5'd9);
        out_ready[1] = 1'b1;
        step();
        idle(1);
        check("fl_valid", out_valid[1], 1'b0);
        check("fl_ready", in_ready[1], 1'b1);
        check("fl_mcnt", misalign_cnt[1], 8'd0);
        step();
        check("fl_never", out_valid[1], 1'b0);

        // randomized phase
        mcnt[0] = 255;
        mcnt[1] = 0;
        exp_q0.delete();
        exp_q1.delete();
        for (int n = 0; n < 800; n++) rand_step();

        // asynchronous reset with two entries queued
        idle(0);
        idle(1);
        flush[0] = 1'b1;
        flush[1] = 1'b1;
        step();
        flush[0] = 1'b0;
        flush[1] = 1'b0;
        beat(0, 32'h0000000A, 2'd0, 2'b10, 1'b0, 5'd10);
        step();
        beat(0, 32'h0000000B, 2'd0, 2'b10, 1'b0, 5'd11);
        step();
        in_valid[0] = 1'b0;
        check("ar_pre_valid", out_valid[0], 1'b1);
        check("ar_pre_full", in_ready[0], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid[0], 1'b0);
        check("ar_ready", in_ready[0], 1'b1);
        check("ar_mcnt", misalign_cnt[0], 8'd0);
        check("ar_data", out_data[0], 32'h0);
        check("ar_tag", out_tag[0], 5'h0);
        check("ar_mcnt_be", misalign_cnt[1], 8'd0);
        step();
        rst_n = 1'b1;
        step();
        check("ar_after", out_valid[0], 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_align_ext.md
# load_align_ext

Parametrised load-data alignment and extension unit with an output queue, placed between the data-memory read port and the register-file write-back in the mMIPS memory stage. Each accepted load beat selects a byte, halfword, word or doubleword from the memory word by address offset, extends it to DATA_W bits, and queues it with its destination tag. A valid/ready handshake on both sides lets write-back stall without losing loads. Misaligned accesses are flagged and counted.

## Interface
- DATA_W, 32: memory word and result width; only 32 or 64 are legal.
- DEPTH, 2: output queue entries; must be a power of two and at least 2.
- TAG_W, 5: destination-register tag width.
- BIG_ENDIAN, 0: 0 means byte k is data[8k+7:8k]; 1 means byte k is data[DATA_W-1-8k -: 8].
- OFF_W is derived as log2(DATA_W/8).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset; release is synchronous to clk.
- flush  in  1  synchronous; empties the queue.
- in_valid  in  1  load beat present.
- in_ready  out  1  equals !full.
- in_data  in  DATA_W  raw memory word.
- in_off  in  OFF_W  low address bits.
- in_size  in  2  access size: 00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_W=64).
- in_unsigned  in  1  marks LBU/LHU/LWU.
- in_tag  in  TAG_W  destination register.
- out_valid  out  1  queue not empty.
- out_ready  in  1  write-back accepts.
- out_data  out  DATA_W  extended result at the queue head.
- out_tag  out  TAG_W  tag of the head entry.
- out_misalign  out  1  misalign flag of the head entry.
- misalign_cnt  out  8  saturating count of misaligned beats accepted.

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Field extraction:
  - Width is 8 << in_size bits, starting at byte in_off under BIG_ENDIAN ordering.
  - Upper bits are filled by the extension rule (see Configuration).
- Misaligned when in_off is not a multiple of the access size in bytes.
- In-size 11 when DATA_W=32 is also treated as misaligned.
- A misaligned push stores data 0 with misalign=1 and increments misalign_cnt, which stops at 255.
- Queue state:
  - Circular buffer with read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy count from 0 to DEPTH; full is count==DEPTH, empty is count==0.
- Simultaneous push and pop:
  - When not empty: both occur and the count is unchanged.
  - When empty: the pushed entry appears the next cycle, with no bypass.
  - When full: in_ready=0, so only the pop occurs.
- flush:
  - Clears pointers and count on the next edge.
  - Overrides any push or pop in the same cycle; a beat offered that cycle is dropped and not counted.
  - misalign_cnt is not cleared.
- Reset mid-operation discards all entries immediately, with no write-back.

## Timing
- Reset values:
  - out_valid=0, in_ready=1, count=0, misalign_cnt=0.
  - out_data, out_tag and out_misalign read 0 because the storage array is cleared.
- Latency from push to out_valid is 1 cycle.
- Throughput is 1 beat per cycle while out_ready stays high.
- in_ready is combinational from count only, with no path from out_ready. A full queue therefore stalls the producer for one cycle even when a pop occurs that cycle.
- Outputs are stable while out_valid && !out_ready.

## Configuration
- LOAD_SIGNEXT_EN defined:
  - in_unsigned=0 sign-extends from the field MSB, as the MIPS ISA specifies.
  - in_unsigned=1 zero-extends.
- LOAD_SIGNEXT_EN undefined:
  - All sub-word fields zero-extend regardless of in_unsigned.
  - This matches the GNU toolchain assumption the existing core relies on.
- A full-width access (word when DATA_W=32, dword when DATA_W=64) is never extended in either mode.

## Test plan
- Sign-extension modes: DATA_W=32, little-endian, data 0x80FF7F01, byte, off=3, signed.
  - With LOAD_SIGNEXT_EN: out_data 0xFFFFFF80 one cycle later.
  - Without it: 0x00000080.
- Big-endian halfword: BIG_ENDIAN=1, data 0x1234ABCD, half, off=2, signed, LOAD_SIGNEXT_EN defined.
  - Required: 0xFFFFABCD.
  - The same beat with unsigned=1 gives 0x0000ABCD.
- Misalignment: half at off=1, then word at off=2.
  - Both entries carry out_misalign=1 and data 0.
  - misalign_cnt=2.
  - After 300 misaligned beats misalign_cnt holds 255.
- Backpressure and wrap: DEPTH=2, out_ready=0, push tags 1,2,3.
  - in_ready drops after 2 pushes and tag 3 is held.
  - Raise out_ready: the outputs are tags 1,2,3 in order, with the pointers wrapping.
- Flush priority: queue holding 1 entry; in one cycle assert flush, in_valid and out_ready.
  - Next cycle out_valid=0, count=0, and the offered beat never appears.
- Async reset: assert rst_n=0 mid-stream with 2 entries queued and no clock edge.
  - out_valid=0 and in_ready=1 immediately.
  - misalign_cnt=0.
